// File: rtl/bist_boot_pkg.sv
// Shared state encoding and default timing constants for the BIST boot sequencer.
package bist_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_BOOT  = 3'd4,
        ST_FAIL  = 3'd5
    } state_e;

    localparam int DEF_RESET_WAIT_CYCLES = 4;
    localparam int DEF_START_CYCLES      = 2;
    localparam int DEF_TIMEOUT_CYCLES    = 1000000;
    localparam int DEF_MAX_RETRIES       = 1;

    // One shared counter serves every timed state, so it must hold the largest limit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int w;
        w = $clog2(a + 1);
        if ($clog2(b + 1) > w) w = $clog2(b + 1);
        if ($clog2(c + 1) > w) w = $clog2(c + 1);
        return w;
    endfunction

endpackage

// File: rtl/bist_timeout_cnt.sv
// Saturating cycle counter; done_o flags the limit_i-th counted cycle (limit_i >= 1).
module bist_timeout_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   cnt_q <= '0;
        else if (clr_i)                cnt_q <= '0;
        else if (en_i && cnt_q != '1)  cnt_q <= cnt_q + W'(1);
    end

    assign done_o = (cnt_q >= limit_i - W'(1));

endmodule

// File: rtl/bist_boot_seq.sv
// Boot sequencer: waits after reset, runs BIST with retry/timeout, then releases the core.
module bist_boot_seq
    import bist_boot_pkg::*;
#(
    parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES,
    parameter int START_CYCLES      = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               bypass_i,
    input  logic                               test_i,
    input  logic                               go_nogo_i,
    output logic                               start_test_o,
    output logic                               core_rst_no,
    output logic                               fetch_enable_o,
    output logic                               pass_o,
    output logic                               fail_o,
    output logic                               timeout_o,
    output logic [2:0]                         state_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries_o
);

    localparam int CW = cnt_width(RESET_WAIT_CYCLES, START_CYCLES, TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    state_e          state_q, state_d;
    logic            seen_busy_q, seen_busy_d;
    logic            go_q, go_d;
    logic [RW-1:0]   retries_q, retries_d;
    logic            pass_d, fail_d, timeout_d;
    logic            cnt_en, cnt_clr, cnt_done;
    logic [CW-1:0]   cnt_limit;

    bist_timeout_cnt #(.W(CW)) u_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (cnt_limit),
        .done_o  (cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        go_d        = go_q;
        retries_d   = retries_q;
        pass_d      = pass_o;
        fail_d      = fail_o;
        timeout_d   = timeout_o;
        cnt_en      = 1'b0;
        cnt_limit   = CW'(RESET_WAIT_CYCLES);
        case (state_q)
            ST_IDLE: begin
                cnt_en = 1'b1;
                if (cnt_done) state_d = bypass_i ? ST_BOOT : ST_START;
            end
            ST_START: begin
                cnt_en    = 1'b1;
                cnt_limit = CW'(START_CYCLES);
                if (cnt_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_en    = 1'b1;
                cnt_limit = CW'(TIMEOUT_CYCLES);
                if (test_i) seen_busy_d = 1'b1;
                // Timeout wins even if the test finishes on the very same cycle.
                if (cnt_done) begin
                    state_d   = ST_FAIL;
                    timeout_d = 1'b1;
                end else if (!test_i && seen_busy_q) begin
                    state_d = ST_CHECK;
                    go_d    = go_nogo_i;
                end
            end
            ST_CHECK: begin
                if (go_q) begin
                    state_d = ST_BOOT;
                    pass_d  = 1'b1;
                end else if (retries_q < RW'(MAX_RETRIES)) begin
                    state_d     = ST_START;
                    retries_d   = retries_q + RW'(1);
                    seen_busy_d = 1'b0;
                end else begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                end
            end
            ST_BOOT, ST_FAIL: state_d = state_q;
            default:          state_d = ST_IDLE;
        endcase
        // Every state change restarts the shared counter.
        cnt_clr = (state_d != state_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            seen_busy_q    <= 1'b0;
            go_q           <= 1'b0;
            retries_q      <= '0;
            start_test_o   <= 1'b0;
            core_rst_no    <= 1'b0;
            fetch_enable_o <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            timeout_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            seen_busy_q    <= seen_busy_d;
            go_q           <= go_d;
            retries_q      <= retries_d;
            start_test_o   <= (state_d == ST_START);
            core_rst_no    <= (state_d == ST_BOOT);
            // Fetch trails the core reset release by one cycle.
            fetch_enable_o <= (state_q == ST_BOOT);
            pass_o         <= pass_d;
            fail_o         <= fail_d;
            timeout_o      <= timeout_d;
        end
    end

    assign state_o   = state_q;
    assign retries_o = retries_q;

endmodule

// File: tb/tb_bist_boot_seq.sv
// Directed bench for bist_boot_seq: hand-timed test_i windows, recorded event cycles vs constants.
module tb_bist_boot_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       bypass_i = 1'b0;
    logic       test_i = 1'b0;
    logic       go_nogo_i = 1'b0;
    logic       start_test_o, core_rst_no, fetch_enable_o;
    logic       pass_o, fail_o, timeout_o;
    logic [2:0] state_o;
    logic [0:0] retries_o;

    int n_vec = 0;
    int n_err = 0;

    // Event records, cycle numbers counted in posedges since reset release (-1 = never).
    int   hi, rises, f_chk, f_boot, f_pass, f_crst, f_fetch, f_to, f_fail;
    logic both, prev_start;

    bist_boot_seq #(
        .RESET_WAIT_CYCLES (4),
        .START_CYCLES      (2),
        .TIMEOUT_CYCLES    (16),
        .MAX_RETRIES       (1)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bypass_i       (bypass_i),
        .test_i         (test_i),
        .go_nogo_i      (go_nogo_i),
        .start_test_o   (start_test_o),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .pass_o         (pass_o),
        .fail_o         (fail_o),
        .timeout_o      (timeout_o),
        .state_o        (state_o),
        .retries_o      (retries_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [31:0] outs();
        return {22'd0, start_test_o, core_rst_no, fetch_enable_o, pass_o, fail_o,
                timeout_o, state_o, retries_o};
    endfunction

    // Busy windows [b1s,b1e] and [b2s,b2e]; go is driven on the cycle after each window.
    task automatic run_seq(input logic byp, input int b1s, input int b1e, input logic go1,
                           input int b2s, input int b2e, input logic go2,
                           input int ncyc, input int rst_at);
        rst_ni = 1'b0; bypass_i = byp; test_i = 1'b0; go_nogo_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_vals", outs(), 32'd0);
        rst_ni = 1'b1;
        hi = 0; rises = 0; f_chk = -1; f_boot = -1; f_pass = -1; f_crst = -1;
        f_fetch = -1; f_to = -1; f_fail = -1; both = 1'b0; prev_start = 1'b0;
        for (int c = 0; c <= ncyc; c++) begin
            if (c > 0) @(negedge clk_i);
            if (start_test_o) hi++;
            if (start_test_o && !prev_start) rises++;
            prev_start = start_test_o;
            if (f_chk   < 0 && state_o == 3'd3) f_chk   = c;
            if (f_boot  < 0 && state_o == 3'd4) f_boot  = c;
            if (f_pass  < 0 && pass_o)          f_pass  = c;
            if (f_crst  < 0 && core_rst_no)     f_crst  = c;
            if (f_fetch < 0 && fetch_enable_o)  f_fetch = c;
            if (f_to    < 0 && timeout_o)       f_to    = c;
            if (f_fail  < 0 && fail_o)          f_fail  = c;
            if (pass_o && fail_o) both = 1'b1;
            if (c == rst_at) begin
                chk("midrst.state_before", 32'(state_o), 32'd2);
                rst_ni = 1'b0;
                #1;
                chk("midrst.async_vals", outs(), 32'd0);
                return;
            end
            test_i    = (c >= b1s && c <= b1e) || (c >= b2s && c <= b2e);
            go_nogo_i = (c == b1e + 1) ? go1 : (c == b2e + 1) ? go2 : 1'b0;
        end
    endtask

    task automatic expect_seq(input string tag, input int e_hi, input int e_rises,
                              input int e_chk, input int e_boot, input int e_pass,
                              input int e_crst, input int e_fetch, input int e_to,
                              input int e_fail, input int e_st, input int e_rt);
        chk({tag, ".start_hi"},    hi,      e_hi);
        chk({tag, ".start_pulses"}, rises,  e_rises);
        chk({tag, ".check_cyc"},   f_chk,   e_chk);
        chk({tag, ".boot_cyc"},    f_boot,  e_boot);
        chk({tag, ".pass_cyc"},    f_pass,  e_pass);
        chk({tag, ".core_rst_cyc"}, f_crst, e_crst);
        chk({tag, ".fetch_cyc"},   f_fetch, e_fetch);
        chk({tag, ".timeout_cyc"}, f_to,    e_to);
        chk({tag, ".fail_cyc"},    f_fail,  e_fail);
        chk({tag, ".end_state"},   32'(state_o),   e_st);
        chk({tag, ".retries"},     32'(retries_o), e_rt);
        chk({tag, ".pass_and_fail"}, 32'(both), 32'd0);
    endtask

    initial begin
        // IDLE 0-3, START 4-5, RUN from 6; test falls at 13 -> CHECK 14, BOOT 15.
        run_seq(1'b0, 8, 12, 1'b1, -1, -2, 1'b0, 24, -1);
        expect_seq("pass", 2, 1, 14, 15, 15, 15, 16, -1, -1, 4, 0);

        // test_i pulsing during IDLE must not arm completion.
        run_seq(1'b0, 1, 2, 1'b0, 8, 12, 1'b1, 24, -1);
        expect_seq("idle_glitch", 2, 1, 14, 15, 15, 15, 16, -1, -1, 4, 0);

        // Retry: CHECK 14 -> START 15-16, RUN 17, test falls 24 -> CHECK 25, BOOT 26.
        run_seq(1'b0, 8, 12, 1'b0, 19, 23, 1'b1, 32, -1);
        expect_seq("retry", 4, 2, 14, 26, 26, 26, 27, -1, -1, 4, 1);

        run_seq(1'b0, 8, 12, 1'b0, 19, 23, 1'b0, 32, -1);
        expect_seq("dbl_fail", 4, 2, 14, -1, -1, -1, -1, -1, 26, 5, 1);

        // RUN entered at 6, timeout 16 cycles later.
        run_seq(1'b0, -1, -2, 1'b0, -1, -2, 1'b0, 24, -1);
        expect_seq("timeout", 2, 1, -1, -1, -1, -1, -1, 22, -1, 5, 0);

        // Completion on the last allowed RUN cycle loses to the timeout.
        run_seq(1'b0, 8, 20, 1'b1, -1, -2, 1'b0, 24, -1);
        expect_seq("to_prio", 2, 1, -1, -1, -1, -1, -1, 22, -1, 5, 0);

        // One cycle earlier the completion wins.
        run_seq(1'b0, 8, 19, 1'b1, -1, -2, 1'b0, 26, -1);
        expect_seq("late_done", 2, 1, 21, 22, 22, 22, 23, -1, -1, 4, 0);

        // Bypass: BOOT after the reset wait, test activity in BOOT ignored.
        run_seq(1'b1, 8, 12, 1'b1, -1, -2, 1'b0, 20, -1);
        expect_seq("bypass", 0, 0, -1, 4, -1, 4, 5, -1, -1, 4, 0);

        // Reset mid-RUN, then a fresh full sequence.
        run_seq(1'b0, 8, 12, 1'b1, -1, -2, 1'b0, 10, 10);
        run_seq(1'b0, 8, 12, 1'b1, -1, -2, 1'b0, 24, -1);
        expect_seq("after_rst", 2, 1, 14, 15, 15, 15, 16, -1, -1, 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bist_boot_seq.md
BIST_BOOT_SEQ -- requirements
Module: bist_boot_seq

Interface
REQ-001 SHALL have parameter RESET_WAIT_CYCLES, default 4, meaning cycles after reset release before BIST start.
REQ-002 SHALL have parameter START_CYCLES, default 2, meaning cycles start_test_o is held asserted.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning max cycles in RUN before abort.
REQ-004 SHALL have parameter MAX_RETRIES, default 1, meaning extra BIST runs allowed after a no-go.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock, rising edge active.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port bypass_i, input, 1 bit: skip BIST and boot the core directly.
REQ-008 SHALL have port test_i, input, 1 bit: BIST busy, high while the test is running.
REQ-009 SHALL have port go_nogo_i, input, 1 bit: BIST result, 1 = pass, valid on the cycle test_i falls.
REQ-010 SHALL have port start_test_o, output, 1 bit: BIST start request to the wrapper.
REQ-011 SHALL have port core_rst_no, output, 1 bit: active-low core reset.
REQ-012 SHALL have port fetch_enable_o, output, 1 bit: core fetch enable.
REQ-013 SHALL have port pass_o, fail_o, timeout_o, outputs, 1 bit each: sticky status flags.
REQ-014 SHALL have port state_o, output, 3 bits: current state encoding, for debug.
REQ-015 SHALL have port retries_o, output, $clog2(MAX_RETRIES+1) bits: number of retries used.

Function
REQ-016 States SHALL be IDLE=0, START=1, RUN=2, CHECK=3, BOOT=4, FAIL=5.
REQ-017 IDLE SHALL count RESET_WAIT_CYCLES cycles, then go to BOOT if bypass_i=1, else to START.
REQ-018 START SHALL hold start_test_o=1 for exactly START_CYCLES cycles, then go to RUN.
REQ-019 RUN SHALL set an internal seen_busy flag on the first cycle test_i=1.
REQ-020 RUN SHALL go to CHECK on the first cycle with test_i=0 and seen_busy=1, and SHALL register go_nogo_i in that same cycle.
REQ-021 RUN SHALL increment a saturating cycle counter sized $clog2(TIMEOUT_CYCLES+1) bits.
REQ-022 When the counter reaches TIMEOUT_CYCLES, RUN SHALL go to FAIL and set timeout_o; timeout SHALL take priority over completion when both occur in the same cycle.
REQ-023 CHECK SHALL go to BOOT and set pass_o when the registered go is 1.
REQ-024 CHECK SHALL go back to START when go is 0 and retries_o < MAX_RETRIES, incrementing retries_o and clearing seen_busy and the counter.
REQ-025 CHECK SHALL otherwise go to FAIL and set fail_o.
REQ-026 BOOT SHALL drive core_rst_no=1 on the first BOOT cycle and fetch_enable_o=1 from the next cycle onward; BOOT is terminal.
REQ-027 FAIL SHALL be terminal, with core_rst_no=0 and fetch_enable_o=0.
REQ-028 Outside BOOT, core_rst_no SHALL be 0 and fetch_enable_o SHALL be 0.
REQ-029 pass_o and fail_o SHALL never both be 1.
REQ-030 go_nogo_i SHALL be ignored while test_i=1.
REQ-031 test_i activity during IDLE or BOOT SHALL be ignored.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 Asserting rst_ni=0 in any state SHALL immediately force state IDLE and clear all counters, seen_busy and retries_o.
REQ-034 Reset values SHALL be: start_test_o=0, core_rst_no=0, fetch_enable_o=0, pass_o=0, fail_o=0, timeout_o=0, state_o=0, retries_o=0.
REQ-035 Reset asserted mid-RUN SHALL abort the sequence, and a full sequence SHALL restart on release.

Structure
REQ-036 The state enum and the default parameter constants SHALL live in shared package bist_boot_pkg.
REQ-037 The block SHALL contain one sub-module, bist_timeout_cnt: a saturating counter with clear and enable inputs and a done output, reused for both the IDLE wait and the RUN timeout.
REQ-038 The block SHALL be instantiated alongside riscv_wrapper, driving its start_test, rst_ni and fetch_enable_i inputs.

Verification (bench parameters RESET_WAIT=4, START=2, TIMEOUT=16, MAX_RETRIES=1)
REQ-039 Pass: test_i high cycles 8-12, go=1 -> start_test_o high exactly 2 cycles, pass_o=1, core_rst_no=1 one cycle after CHECK, fetch_enable_o=1 one cycle later.
REQ-040 Retry: first run go=0, second run go=1 -> two start_test_o pulses, retries_o=1, pass_o=1.
REQ-041 Double fail: go=0 on both runs -> fail_o=1, retries_o=1, core_rst_no stays 0.
REQ-042 Timeout: test_i never rises -> timeout_o=1 exactly 16 cycles after entering RUN, state_o=5.
REQ-043 Bypass: bypass_i=1 -> start_test_o never asserted, state_o=4 after 4 cycles, pass_o=0.
REQ-044 Mid-run reset: rst_ni pulsed low during RUN -> all outputs return to reset values asynchronously, and a fresh sequence completes with pass_o=1.
